// File: rtl/card_pkg.sv
// Shared types and constants for the baccarat card shoe.
package card_pkg;

    typedef logic [3:0] rank_t;

    localparam int unsigned NUM_RANKS = 13;
    localparam int unsigned FACE_MIN  = 10;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    // Tens and face cards score zero in baccarat.
    function automatic rank_t rank_to_value(input rank_t rank);
        return (rank < rank_t'(FACE_MIN)) ? rank : rank_t'(0);
    endfunction

endpackage

// File: rtl/rank_seed_counter.sv
// Free-running 1..13 wrapping counter that picks the starting rank of each scan.
module rank_seed_counter
    import card_pkg::*;
(
    input  logic  clock,
    input  logic  resetb,
    output rank_t o_seed
);

    rank_t r_seed;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_seed <= rank_t'(1);
        end else if (r_seed == rank_t'(NUM_RANKS)) begin
            r_seed <= rank_t'(1);
        end else begin
            r_seed <= r_seed + rank_t'(1);
        end
    end

    assign o_seed = r_seed;

endmodule

// File: rtl/card_shoe.sv
// Deals cards without replacement from a shoe of COPIES x 13 ranks, one per request.
module card_shoe
    import card_pkg::*;
#(
    parameter int unsigned COPIES = 4
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       shuffle,
    input  logic       deal_req,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [3:0] card_value,
    output logic       busy,
    output logic       empty,
    output logic [5:0] cards_left
);

    localparam logic [2:0] FULL_COUNT = 3'(COPIES);
    localparam logic [5:0] FULL_SHOE  = 6'(NUM_RANKS * COPIES);

    state_t     r_state;
    state_t     w_state_next;
    rank_t      r_ptr;
    rank_t      r_rank;
    rank_t      w_seed;
    logic [2:0] r_count [1:NUM_RANKS];
    logic [5:0] r_left;
    logic       r_valid;
    logic       w_accept;
    logic       w_hit;

    rank_seed_counter u_seed (
        .clock  (clock),
        .resetb (resetb),
        .o_seed (w_seed)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_hit        = 1'b0;
        if (shuffle) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (deal_req && (r_left != 6'd0)) begin
                        w_accept     = 1'b1;
                        w_state_next = SCAN;
                    end
                end
                SCAN: begin
                    if (r_count[r_ptr] != 3'd0) begin
                        w_hit        = 1'b1;
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 1; i <= NUM_RANKS; i++) begin
                r_count[i] <= FULL_COUNT;
            end
            r_left  <= FULL_SHOE;
            r_ptr   <= rank_t'(1);
            r_rank  <= rank_t'(0);
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_hit;
            if (shuffle) begin
                for (int i = 1; i <= NUM_RANKS; i++) begin
                    r_count[i] <= FULL_COUNT;
                end
                r_left <= FULL_SHOE;
            end else if (w_accept) begin
                r_ptr <= w_seed;
            end else if (w_hit) begin
                r_count[r_ptr] <= r_count[r_ptr] - 3'd1;
                r_left         <= r_left - 6'd1;
                r_rank         <= r_ptr;
            end else if (r_state == SCAN) begin
                r_ptr <= (r_ptr == rank_t'(NUM_RANKS)) ? rank_t'(1) : r_ptr + rank_t'(1);
            end
        end
    end

    assign card_valid = r_valid;
    assign card_rank  = r_rank;
    assign card_value = rank_to_value(r_rank);
    assign busy       = (r_state == SCAN);
    assign empty      = (r_left == 6'd0);
    assign cards_left = r_left;

endmodule

// File: tb/tb_card_shoe.sv
// Directed self-checking bench for card_shoe.
module tb_card_shoe;

    logic       clock;
    logic       resetb;
    logic       shuffle;
    logic       deal_req;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [3:0] card_value;
    logic       busy;
    logic       empty;
    logic [5:0] cards_left;

    int checks;
    int errors;

    // Bench-side seed: the value the shoe will sample at the next rising edge.
    logic [3:0] exp_seed;

    card_shoe #(.COPIES(4)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .shuffle    (shuffle),
        .deal_req   (deal_req),
        .card_valid (card_valid),
        .card_rank  (card_rank),
        .card_value (card_value),
        .busy       (busy),
        .empty      (empty),
        .cards_left (cards_left)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge resetb) begin
        if (!resetb) exp_seed <= 4'd1;
        else         exp_seed <= (exp_seed == 4'd13) ? 4'd1 : exp_seed + 4'd1;
    end

    // Request a card on the edge where the seed equals s; reports rank, value, latency, busy cycles.
    task automatic deal(input logic [3:0] s, output logic [3:0] rk, output logic [3:0] vl,
                        output int lat, output int bcnt);
        int guard;
        guard = 0;
        while (exp_seed !== s && guard < 30) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 30) begin
            checks++;
            errors++;
            $display("FAIL seed_wait: seed %0d never reached", s);
        end
        deal_req = 1'b1;
        @(negedge clock);
        deal_req = 1'b0;
        lat  = 0;
        bcnt = 0;
        rk   = 4'd0;
        vl   = 4'd0;
        for (int i = 1; i <= 14; i++) begin
            if (busy) bcnt++;
            @(negedge clock);
            if (card_valid) begin
                lat = i;
                rk  = card_rank;
                vl  = card_value;
                break;
            end
        end
    endtask

    task automatic test_reset;
        resetb   = 1'b0;
        shuffle  = 1'b0;
        deal_req = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({card_valid, card_rank, card_value, busy, empty} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b r=%0d val=%0d busy=%b empty=%b, want all 0",
                     card_valid, card_rank, card_value, busy, empty);
        end
        checks++;
        if (cards_left !== 6'd52) begin
            errors++;
            $display("FAIL reset_left: got %0d want 52", cards_left);
        end
        resetb = 1'b1;
    endtask

    task automatic test_first_deal;
        logic [3:0] rk, vl;
        int lat, bc;
        deal(4'd1, rk, vl, lat, bc);
        checks++;
        if (rk !== 4'd1 || vl !== 4'd1 || lat != 1) begin
            errors++;
            $display("FAIL first_deal: got rank=%0d val=%0d lat=%0d want 1/1/1", rk, vl, lat);
        end
        checks++;
        if (cards_left !== 6'd51) begin
            errors++;
            $display("FAIL first_left: got %0d want 51", cards_left);
        end
    endtask

    task automatic test_face;
        logic [3:0] rk, vl;
        int lat, bc;
        deal(4'd12, rk, vl, lat, bc);
        checks++;
        if (rk !== 4'd12 || vl !== 4'd0 || lat != 1) begin
            errors++;
            $display("FAIL face_card: got rank=%0d val=%0d lat=%0d want 12/0/1", rk, vl, lat);
        end
        checks++;
        if (cards_left !== 6'd50) begin
            errors++;
            $display("FAIL face_left: got %0d want 50", cards_left);
        end
    endtask

    task automatic test_exhaust;
        logic [3:0] rk, vl;
        int lat, bc;
        int bad;
        bad = 0;
        for (int n = 0; n < 4; n++) begin
            deal(4'd10, rk, vl, lat, bc);
            if (rk !== 4'd10 || vl !== 4'd0 || lat != 1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL exhaust_tens: %0d of 4 deals not rank 10 / value 0 / latency 1", bad);
        end
        deal(4'd10, rk, vl, lat, bc);
        checks++;
        if (rk !== 4'd11 || vl !== 4'd0 || lat != 2 || bc != 2) begin
            errors++;
            $display("FAIL exhaust_miss: got rank=%0d val=%0d lat=%0d busy=%0d want 11/0/2/2",
                     rk, vl, lat, bc);
        end
        checks++;
        if (cards_left !== 6'd45) begin
            errors++;
            $display("FAIL exhaust_left: got %0d want 45", cards_left);
        end
    endtask

    task automatic test_busy_ignore;
        int guard, pulses;
        logic [3:0] last;
        guard = 0;
        while (exp_seed !== 4'd10 && guard < 30) begin
            @(negedge clock);
            guard++;
        end
        deal_req = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_high: got %b want 1", busy);
        end
        // Keep requesting while the miss scan is in flight.
        @(negedge clock);
        deal_req = 1'b0;
        pulses = 0;
        last   = 4'd0;
        if (card_valid) begin
            pulses++;
            last = card_rank;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (card_valid) begin
                pulses++;
                last = card_rank;
            end
        end
        checks++;
        if (pulses != 1 || last !== 4'd11) begin
            errors++;
            $display("FAIL busy_ignore: got %0d pulses rank=%0d want 1 pulse rank 11", pulses, last);
        end
        checks++;
        if (cards_left !== 6'd44) begin
            errors++;
            $display("FAIL busy_left: got %0d want 44", cards_left);
        end
    endtask

    task automatic test_shuffle;
        int guard, pulses, busy_seen;
        guard = 0;
        while (exp_seed !== 4'd10 && guard < 30) begin
            @(negedge clock);
            guard++;
        end
        deal_req = 1'b1;
        @(negedge clock);
        deal_req = 1'b0;
        shuffle  = 1'b1;
        @(negedge clock);
        shuffle   = 1'b0;
        pulses    = card_valid ? 1 : 0;
        busy_seen = busy ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (card_valid) pulses++;
            if (busy) busy_seen++;
        end
        checks++;
        if (pulses != 0 || busy_seen != 0) begin
            errors++;
            $display("FAIL shuffle_abort: got %0d pulses, busy %0d cycles want 0/0",
                     pulses, busy_seen);
        end
        checks++;
        if (cards_left !== 6'd52 || empty !== 1'b0 || card_rank !== 4'd11) begin
            errors++;
            $display("FAIL shuffle_state: got left=%0d empty=%b rank=%0d want 52/0/11",
                     cards_left, empty, card_rank);
        end
        shuffle  = 1'b1;
        deal_req = 1'b1;
        @(negedge clock);
        shuffle   = 1'b0;
        deal_req  = 1'b0;
        pulses    = 0;
        busy_seen = busy ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (card_valid) pulses++;
            if (busy) busy_seen++;
        end
        checks++;
        if (pulses != 0 || busy_seen != 0 || cards_left !== 6'd52) begin
            errors++;
            $display("FAIL shuffle_beats_deal: got %0d pulses busy=%0d left=%0d want 0/0/52",
                     pulses, busy_seen, cards_left);
        end
    endtask

    task automatic test_drain;
        logic [3:0] rk, vl;
        int lat, bc, missing, pulses, busy_seen;
        int hist [1:13];
        int bad_hist;
        missing = 0;
        for (int r = 1; r <= 13; r++) hist[r] = 0;
        for (int n = 0; n < 52; n++) begin
            deal(exp_seed, rk, vl, lat, bc);
            if (lat == 0 || rk < 4'd1 || rk > 4'd13) missing++;
            else hist[rk]++;
        end
        checks++;
        if (missing != 0) begin
            errors++;
            $display("FAIL drain_deals: %0d of 52 requests gave no valid card", missing);
        end
        bad_hist = 0;
        for (int r = 1; r <= 13; r++) if (hist[r] != 4) bad_hist++;
        checks++;
        if (bad_hist != 0) begin
            errors++;
            $display("FAIL drain_ranks: %0d ranks not dealt exactly 4 times", bad_hist);
        end
        checks++;
        if (cards_left !== 6'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got left=%0d empty=%b want 0/1", cards_left, empty);
        end
        deal_req = 1'b1;
        @(negedge clock);
        deal_req  = 1'b0;
        pulses    = 0;
        busy_seen = busy ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (card_valid) pulses++;
            if (busy) busy_seen++;
        end
        checks++;
        if (pulses != 0 || busy_seen != 0) begin
            errors++;
            $display("FAIL drain_53rd: got %0d pulses busy=%0d want 0/0", pulses, busy_seen);
        end
    endtask

    task automatic test_reset_midscan;
        logic [3:0] rk, vl;
        int lat, bc, guard;
        shuffle = 1'b1;
        @(negedge clock);
        shuffle = 1'b0;
        for (int n = 0; n < 4; n++) deal(4'd10, rk, vl, lat, bc);
        guard = 0;
        while (exp_seed !== 4'd10 && guard < 30) begin
            @(negedge clock);
            guard++;
        end
        deal_req = 1'b1;
        @(negedge clock);
        deal_req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midscan_busy: got %b want 1", busy);
        end
        #2 resetb = 1'b0;
        #1;
        checks++;
        if ({card_valid, card_rank, card_value, busy, empty} !== 11'd0 || cards_left !== 6'd52) begin
            errors++;
            $display("FAIL reset_midscan: got v=%b r=%0d val=%0d busy=%b empty=%b left=%0d want 0s/52",
                     card_valid, card_rank, card_value, busy, empty, cards_left);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (card_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got v=%b busy=%b want 0/0", card_valid, busy);
        end
        resetb = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        resetb   = 1'b0;
        shuffle  = 1'b0;
        deal_req = 1'b0;
        @(negedge clock);
        test_reset;
        test_first_deal;
        test_face;
        test_exhaust;
        test_busy_ignore;
        test_shuffle;
        test_drain;
        test_reset_midscan;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_shoe.md
# card_shoe

Sequential card source for the baccarat datapath. It models a shoe of `COPIES` × 13 ranks and deals one card per request without replacement. Each dealt card carries its rank and its baccarat point value (face cards and tens score 0), so the value feeds straight into the hand-scoring adder, which sums card values modulo 10. It sits between the game state machine, which issues requests, and the per-hand card registers.

## Interface
- `COPIES`, default 4: copies of each rank in a full shoe; legal range 1..4.
- `clock`  in  1: rising-edge clock.
- `resetb`  in  1: asynchronous, active-low reset.
- `shuffle`  in  1: one-cycle pulse; refills the shoe.
- `deal_req`  in  1: one-cycle pulse requesting one card.
- `card_valid`  out  1: one-cycle pulse; `card_rank` and `card_value` are new.
- `card_rank`  out  4: 1..13 (A..K); holds until the next `card_valid`.
- `card_value`  out  4: `card_rank` if the rank is below 10, else 0; holds with `card_rank`.
- `busy`  out  1: a scan is in progress; `deal_req` is ignored.
- `empty`  out  1: `cards_left` == 0.
- `cards_left`  out  6: cards remaining in the shoe, 0..13·COPIES.

## Operation
- State per rank: 13 counters, each 3 bits, each holding remaining copies (0..COPIES).
- Seed counter:
  - Free-running; advances every clock regardless of state.
  - Sequence 1→2→…→13→1.
  - Reset value 1.
- FSM states:
  - IDLE: `busy`=0.
  - SCAN: `busy`=1. Register `ptr` holds a rank 1..13.
- IDLE→SCAN: `deal_req`=1 AND `empty`=0 AND `shuffle`=0. On that edge `ptr` ← current seed value.
- SCAN, `count[ptr]` > 0 (hit):
  - `count[ptr]` decrements.
  - `cards_left` decrements.
  - `card_rank` ← `ptr`; `card_value` updates to match.
  - `card_valid` ← 1.
  - Next state IDLE.
- SCAN, `count[ptr]` == 0 (miss):
  - `ptr` advances, wrapping 13→1.
  - Stay in SCAN.
- Scan length: a non-empty shoe always hits within 13 SCAN cycles.
- Ignored requests (no state change):
  - `deal_req` in SCAN.
  - `deal_req` while `empty`=1.
- `shuffle`, in any state:
  - All counts ← COPIES; `cards_left` ← 13·COPIES.
  - FSM → IDLE; an in-flight scan aborts with no `card_valid`.
  - `shuffle` beats `deal_req` in the same cycle; the request is dropped.
  - `card_rank` and `card_value` are unchanged.
- Arithmetic: counts never underflow, because a decrement happens only on a hit. `empty` is combinational from `cards_left`.
- Reset values:
  - FSM IDLE, seed 1, `ptr` 1.
  - All counts COPIES, `cards_left` 13·COPIES.
  - `card_valid` 0, `card_rank` 0, `card_value` 0, `busy` 0, `empty` 0.
- Reset asserted mid-scan: everything returns to reset values immediately; no `card_valid`.

## Timing
- Request sampled at edge T. A hit on the k-th SCAN cycle (k = 1..13) registers `card_valid` at edge T+k, so the pulse is high during cycle T+k.
- Minimum latency 1 cycle after the request edge; maximum 13.
- `busy` is high from edge T to edge T+k; a new request is accepted at edge T+k+1 or later.
- `cards_left` and `card_rank` update on the same edge as `card_valid`.
- `card_valid` is high for exactly one cycle per dealt card.

## Structure
- Package `card_pkg`:
  - `rank_t` (logic [3:0]).
  - Constants `NUM_RANKS`=13 and `FACE_MIN`=10.
  - FSM state enum {IDLE, SCAN}.
  - Function `rank_to_value`.
- Sub-module `rank_seed_counter`: the 1..13 wrapping free-running counter, with clock and resetb ports.

## Test plan
- Deal after reset: release reset, pulse `deal_req` at the first edge (seed 1) → `card_valid` at the next edge, `card_rank`=1, `card_value`=1, `cards_left`=51.
- Face card: request when the seed is 12 → `card_rank`=12, `card_value`=0, latency 1.
- Rank exhaustion: four requests each sampled with seed 10 → four cards of rank 10. A fifth request at seed 10 → miss, then `card_rank`=11, `card_value`=0, latency 2, `busy` high for 2 cycles.
- Drain: 52 accepted requests → `cards_left`=0 and `empty`=1. A 53rd `deal_req` → no `card_valid`, `busy` stays 0.
- Shuffle mid-scan: abort a scan with `shuffle` → no `card_valid`, FSM IDLE, `cards_left`=52, `empty`=0. Simultaneous `shuffle`+`deal_req` → request dropped.
- Busy/reset: `deal_req` while `busy`=1 → ignored, exactly one card out. `resetb` low mid-scan → all outputs return to reset values at once.
